// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: sequencing FSM for the masked 32-bit AES-128 key datapath (forward/inverse schedule).
// Optional KEY_CTRL_REKEY_LOOP_EN adds the rewind input and a 4-cycle REWIND state that restores the original key.
module aes_key_sched_ctrl #(
  parameter int SB_LAT  = 6,
  parameter int NROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_inverse,
  output logic       in_ready,
  input  logic       hold,
`ifdef KEY_CTRL_REKEY_LOOP_EN
  input  logic       rewind,
`endif
  output logic       sb_req,
  output logic       init,
  output logic       enable,
  output logic       loop,
  output logic       add_from_sb,
  output logic       rcon_rst,
  output logic       rcon_update,
  output logic       rcon_inverse,
  output logic       enable_buffer_from_sbox,
  output logic       rst_buffer_from_sbox,
  output logic       col_valid,
  output logic [1:0] col_idx,
  output logic [3:0] round_idx,
  output logic       done
);
`ifdef KEY_CTRL_REKEY_LOOP_EN
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, COL, REWIND} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, COL} state_t;
`endif
  localparam logic [3:0] WAIT_INIT = 4'(SB_LAT - 2);
  localparam logic [3:0] LAST      = 4'(NROUNDS - 1);
  state_t     state, state_n;
  logic [3:0] round, round_n, wcnt, wcnt_n;
  logic [1:0] col, col_n;
  logic       inv, inv_n, done_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      round <= '0;
      col   <= '0;
      wcnt  <= '0;
      inv   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      round <= round_n;
      col   <= col_n;
      wcnt  <= wcnt_n;
      inv   <= inv_n;
      done  <= done_n;
    end
  end
`ifdef KEY_CTRL_REKEY_LOOP_EN
  logic armed;
  // a rewind only makes sense once a full schedule has left the last round key in the datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) armed <= 1'b0;
    else if (done_n) armed <= 1'b1;
    else if (init || state_n == REWIND) armed <= 1'b0;
  end
`endif
  always_comb begin
    state_n = state;
    round_n = round;
    col_n = col;
    wcnt_n = wcnt;
    inv_n = inv;
    done_n = 1'b0;
    in_ready = 1'b0;
    sb_req = 1'b0;
    init = 1'b0;
    enable = 1'b0;
    loop = 1'b0;
    add_from_sb = 1'b0;
    rcon_rst = 1'b0;
    rcon_update = 1'b0;
    enable_buffer_from_sbox = 1'b0;
    rst_buffer_from_sbox = 1'b0;
    col_valid = 1'b0;
    col_idx = state == COL ? col : 2'd0;
    round_idx = state == IDLE ? 4'd0 : round;
    rcon_inverse = state != IDLE && inv;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          init = 1'b1;
          enable = 1'b1;
          rcon_rst = 1'b1;
          inv_n = in_inverse;
          round_n = 4'd0;
          state_n = FETCH;
        end
`ifdef KEY_CTRL_REKEY_LOOP_EN
        else if (rewind && armed && !rst) begin
          col_n = 2'd0;
          state_n = REWIND;
        end
`endif
      end
      FETCH: begin
        sb_req = 1'b1;
        rst_buffer_from_sbox = inv;
        enable_buffer_from_sbox = inv;
        wcnt_n = WAIT_INIT;
        state_n = WAIT;
      end
      // the S-box pipeline cannot stall, so hold is not looked at until COL
      WAIT: begin
        wcnt_n = wcnt == 4'd0 ? wcnt : wcnt - 4'd1;
        col_n = 2'd0;
        state_n = wcnt == 4'd0 ? COL : WAIT;
      end
      COL: if (!hold) begin
        enable = 1'b1;
        col_valid = 1'b1;
        add_from_sb = col == 2'd0;
        enable_buffer_from_sbox = inv;
        col_n = col + 2'd1;
        if (col == 2'd3) begin
          rcon_update = 1'b1;
          done_n = round == LAST;
          round_n = round == LAST ? 4'd0 : round + 4'd1;
          state_n = round == LAST ? IDLE : FETCH;
        end
      end
`ifdef KEY_CTRL_REKEY_LOOP_EN
      REWIND: begin
        loop = 1'b1;
        enable = 1'b1;
        rcon_rst = col == 2'd0;
        col_n = col + 2'd1;
        state_n = col == 2'd3 ? IDLE : REWIND;
      end
`endif
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: scoreboard bench; a timeline model pushes expected events, a monitor checks every cycle.
module tb_aes_key_sched_ctrl;
  localparam int SB_LAT = 6;
  localparam int NR     = 10;
  localparam int HMAX   = 8192;
  localparam int K_INIT = 0, K_SB = 1, K_COL = 2, K_DONE = 3;
  typedef struct {int cyc; int kind; int rnd; int col; bit inv;} ev_t;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_inverse = 1'b0, hold = 1'b0;
  logic in_ready, sb_req, init, enable, loop, add_from_sb, rcon_rst, rcon_update, rcon_inverse;
  logic enable_buffer_from_sbox, rst_buffer_from_sbox, col_valid, done;
  logic [1:0] col_idx;
  logic [3:0] round_idx;
  ev_t q[$];
  bit  hold_pat [0:HMAX-1];
  int  cyc = 0, busy_until = 0, checks = 0, errors = 0;
  bit  cur_inv = 1'b0, finishing = 1'b0;

  aes_key_sched_ctrl #(.SB_LAT(SB_LAT), .NROUNDS(NR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_inverse(in_inverse), .in_ready(in_ready),
    .hold(hold), .sb_req(sb_req), .init(init), .enable(enable), .loop(loop),
    .add_from_sb(add_from_sb), .rcon_rst(rcon_rst), .rcon_update(rcon_update),
    .rcon_inverse(rcon_inverse), .enable_buffer_from_sbox(enable_buffer_from_sbox),
    .rst_buffer_from_sbox(rst_buffer_from_sbox), .col_valid(col_valid), .col_idx(col_idx),
    .round_idx(round_idx), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Timeline of one key: load, then per round one S-box request, SB_LAT cycles later four
  // column steps, each column slipping by one cycle for every held cycle it meets.
  task automatic schedule(input int t0, input bit inv);
    int t;
    q.push_back('{t0, K_INIT, 0, 0, inv});
    t = t0 + 1;
    for (int r = 0; r < NR; r++) begin
      q.push_back('{t, K_SB, r, 0, inv});
      t += SB_LAT;
      for (int c = 0; c < 4; c++) begin
        while (t < HMAX && hold_pat[t]) t++;
        q.push_back('{t, K_COL, r, c, inv});
        t++;
      end
    end
    q.push_back('{t, K_DONE, 0, 0, inv});
    busy_until = t;
    cur_inv = inv;
  endtask

  task automatic drive(input bit v, input bit inv);
    in_valid = v;
    in_inverse = inv;
    hold = cyc < HMAX ? hold_pat[cyc] : 1'b0;
    if (v && cyc >= busy_until) schedule(cyc, inv);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    while (cyc < busy_until) drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    ev_t e;
    bit ie, se, ce, de, einv, rdy;
    int er, ec;
    logic [18:0] act, exp_v, mask;
    act = {in_ready, init, enable, loop, sb_req, add_from_sb, rcon_rst, rcon_update, rcon_inverse,
           enable_buffer_from_sbox, rst_buffer_from_sbox, col_valid, done, col_idx, round_idx};
    if (finishing) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL pending_events got %0d left want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end else if (rst) begin
      checks++;
      if (act != '0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d got %h want 0", cyc, act);
      end
    end else begin
      {ie, se, ce, de, einv} = '0;
      er = 0;
      ec = 0;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        case (e.kind)
          K_INIT: ie = 1'b1;
          K_SB: begin se = 1'b1; er = e.rnd; einv = e.inv; end
          K_COL: begin ce = 1'b1; er = e.rnd; ec = e.col; einv = e.inv; end
          default: de = 1'b1;
        endcase
      end
      rdy = ie || cyc >= busy_until;
      exp_v = {rdy, ie, ie | ce, 1'b0, se, ce && ec == 0, ie, ce && ec == 3, !rdy && cur_inv,
               (se | ce) && einv, se && einv, ce, de, 2'(ec), 4'(er)};
      mask = {13'h1fff, {2{ce}}, {4{se | ce | rdy}}};
      checks++;
      if ((act & mask) != (exp_v & mask)) begin
        errors++;
        $display("FAIL outputs cyc %0d got %h want %h (mask %h)", cyc, act & mask, exp_v & mask, mask);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    for (int i = 0; i < HMAX; i++) hold_pat[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    wait_idle();
    drive(1'b1, 1'b1);
    wait_idle();
    t0 = cyc;
    for (int i = 8; i <= 10; i++) hold_pat[t0 + i] = 1'b1;
    drive(1'b1, 1'b0);
    wait_idle();
    t0 = cyc;
    for (int i = 2; i <= 5; i++) hold_pat[t0 + i] = 1'b1;
    drive(1'b1, 1'b0);
    wait_idle();
    for (int i = 0; i < 102; i++) drive(1'b1, i > 50);
    wait_idle();
    drive(1'b1, 1'b1);
    repeat (49) drive(1'b0, 1'b0);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    busy_until = cyc;
    cur_inv = 1'b0;
    drive(1'b1, 1'b0);
    wait_idle();
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 4)) drive(1'b0, 1'($urandom_range(0, 1)));
      for (int i = cyc; i < cyc + 200 && i < HMAX; i++) hold_pat[i] = $urandom_range(0, 3) == 0;
      drive(1'b1, 1'($urandom_range(0, 1)));
      while (cyc < busy_until - 1) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_idle();
    end
    repeat (4) drive(1'b0, 1'b0);
    finishing = 1'b1;
  end
endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Sequencing FSM that drives the control inputs of the masked 32-bit AES-128 key datapath.
- Accepts a key-load request, steps the datapath through 10 round-key updates, and requests one S-box pass per round.
- Flags each round-key column as it becomes available to AddRoundKey.
- Supports forward schedule (encryption) and inverse schedule (recompute backwards from the last round key).
- Sits between the top-level AES controller and the key datapath. Carries control only, no shares.

Parameters:
- SB_LAT, 6, S-box pipeline latency in cycles from request to valid output; legal range 2..15.
- NROUNDS, 10, number of round-key updates per key.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  new key present on datapath sh_key
- in_inverse  in  1  schedule direction for the new key, sampled with in_valid
- in_ready  out  1  controller idle, key can be accepted
- hold  in  1  AddRoundKey stall; freezes column stepping
- sb_req  out  1  key column presented to S-box this cycle
- init  out  1  datapath load
- enable  out  1  datapath key register enable
- loop  out  1  datapath column rotate without update
- add_from_sb  out  1  datapath select S-box result
- rcon_rst  out  1  reset RCON unit
- rcon_update  out  1  advance RCON
- rcon_inverse  out  1  inverse schedule select
- enable_buffer_from_sbox  out  1  inverse buffer enable
- rst_buffer_from_sbox  out  1  inverse buffer clear
- col_valid  out  1  a round-key column is valid for AddRoundKey
- col_idx  out  2  column index of the valid column
- round_idx  out  4  current round, 0..NROUNDS-1
- done  out  1  one-cycle pulse after the last column

Behaviour:
- States: IDLE, FETCH, WAIT, COL. Registers: state, round counter (4 b), column counter (2 b), wait counter (4 b), latched inverse flag.
- Reset (async, any state): state=IDLE; all counters 0; inverse flag 0; done=0.
  - While rst is high, every output is 0 including in_ready.
  - in_ready goes to 1 on the first cycle with rst low.
- IDLE
  - in_ready=1.
  - If in_valid=1, the same cycle asserts init=1, enable=1, rcon_rst=1 and latches in_inverse; the next state is FETCH with round=0.
  - in_valid in any other state is ignored and the key is not loaded.
- FETCH (1 cycle)
  - sb_req=1, enable=0.
  - In inverse mode, also rst_buffer_from_sbox=1 and enable_buffer_from_sbox=1.
  - Next state is WAIT with wait counter = SB_LAT-2.
- WAIT
  - enable=0.
  - Decrement the wait counter; at 0, go to COL with col=0.
  - Total FETCH+WAIT = SB_LAT cycles.
- COL (4 cycles when hold=0)
  - enable=1, col_valid=1, col_idx=col.
  - add_from_sb=1 only when col=0.
  - In inverse mode, enable_buffer_from_sbox=1 and rst_buffer_from_sbox=0.
  - When col=3: rcon_update=1.
    - If round=NROUNDS-1, go to IDLE and pulse done on the next cycle.
    - Otherwise increment round and go to FETCH.
- hold=1 in COL: enable=0, col_valid=0, rcon_update=0, buffer enables 0; counters frozen.
- hold is ignored in FETCH and WAIT, because the S-box pipeline cannot stall.
- rcon_inverse equals the latched inverse flag in every non-IDLE state and is 0 in IDLE.
- loop=0 throughout. loop is driven only when REKEY_LOOP is compiled in (see Optional Feature).
- Latency with hold=0:
  - Round length is SB_LAT+4 cycles.
  - With accept at cycle 0, the last COL cycle is cycle NROUNDS*(SB_LAT+4), which is 100 for the defaults.
  - done and in_ready are both 1 at cycle 101.
  - A new key can be accepted at cycle 101 (back-to-back).
- round_idx holds its value during hold and FETCH/WAIT, and is 0 in IDLE.

Optional Feature:
- Macro KEY_CTRL_REKEY_LOOP_EN.
- With the macro: a pulse on an extra input rewind (1 b) while in IDLE after a completed schedule restores the original key.
  - The controller spends exactly 4 cycles in state REWIND with loop=1, enable=1 and rcon_rst=1 on the first cycle.
  - in_ready=0 during REWIND; it returns to IDLE afterwards.
  - rewind while in_valid=1 in the same cycle: the load wins and rewind is ignored.
- Without the macro: the rewind port does not exist, loop is tied to 0, and the REWIND state is not present.

Test Plan:
- Reset then in_valid=1, in_inverse=0, hold=0 → init/enable/rcon_rst high in the accept cycle; sb_req at cycles 1, 11, …, 91; col_valid at cycles 7-10, 17-20, …, 97-100; done=1 at cycle 101.
- Same with in_inverse=1 → rcon_inverse=1 cycles 1-100; rst_buffer_from_sbox=1 at cycles 1, 11, …; enable_buffer_from_sbox=1 on all FETCH and COL cycles; done at 101.
- hold=1 for 3 cycles starting at cycle 8 → enable=0 and col_valid=0 during the stall; col_idx stays 1; the round ends 3 cycles late; done at 104.
- hold=1 during cycles 2-5 (WAIT) → no effect; the timing equals the first scenario.
- rst asserted at cycle 50 for 1 cycle → all outputs 0 immediately; in_ready=1 the next cycle; the new key is accepted and runs a full 100-cycle schedule.
- in_valid held high from cycle 0 to 101 → exactly two loads, at cycles 0 and 101; in_ready=0 during cycles 1-100.
